// File: rtl/i2s_dac_tx_if.sv
// Valid/ready handshake that carries stereo sample pairs from the waveform core
// into the I2S transmitter.
interface i2s_dac_tx_if #(
  parameter int DATA_W = 16
);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_left;
  logic [DATA_W-1:0] s_right;

  modport master (output s_valid, output s_left, output s_right, input s_ready);
  modport slave  (input s_valid, input s_left, input s_right, output s_ready);
endinterface

// File: rtl/i2s_dac_tx.sv
// I2S transmitter: buffers one stereo pair and serialises it as BCLK/LRCK/DOUT,
// with all serial outputs updated on BCLK falling edges; idles while the PLL is unlocked.
module i2s_dac_tx #(
  parameter int DATA_W    = 16,
  parameter int SLOT_W    = 32,
  parameter int BCLK_HALF = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pll_locked,
  i2s_dac_tx_if.slave s,
  output logic        i2s_bclk,
  output logic        i2s_lrck,
  output logic        i2s_dout,
  output logic        frame_start,
  output logic        underrun
);
  localparam int FRAME_W = 2 * SLOT_W;
  localparam int CNT_W   = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
  localparam int B_W     = $clog2(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BCLK_HALF - 1);
  localparam logic [B_W-1:0]   B_LAST  = B_W'(FRAME_W - 1);
  localparam logic [B_W-1:0]   LR_LO   = B_W'(SLOT_W - 1);
  localparam logic [B_W-1:0]   LR_HI   = B_W'(FRAME_W - 2);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic               lock_meta_q, lock_s_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [B_W-1:0]     b_q, b_d;
  logic               bclk_q, bclk_d;
  logic               lrck_q, lrck_d;
  logic               dout_q, dout_d;
  logic               frame_start_q, frame_start_d;
  logic               underrun_q, underrun_d;
  logic               s_ready_q, s_ready_d;
  logic [FRAME_W-1:0] shreg_q, shreg_d;
  logic               buf_valid_q, buf_valid_d;
  logic [DATA_W-1:0]  buf_left_q, buf_left_d;
  logic [DATA_W-1:0]  buf_right_q, buf_right_d;
  logic               fall, load, xfer;
  logic [SLOT_W-1:0]  slot_left, slot_right;
  logic [FRAME_W-1:0] frame_new;

  // Samples sit MSB-aligned in their slot; an empty buffer yields a silent frame.
  always_comb begin
    slot_left  = SLOT_W'(buf_left_q) << (SLOT_W - DATA_W);
    slot_right = SLOT_W'(buf_right_q) << (SLOT_W - DATA_W);
    frame_new  = buf_valid_q ? {slot_left, slot_right} : '0;
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    b_d           = b_q;
    bclk_d        = bclk_q;
    lrck_d        = lrck_q;
    dout_d        = dout_q;
    shreg_d       = shreg_q;
    frame_start_d = 1'b0;
    underrun_d    = underrun_q;
    buf_valid_d   = buf_valid_q;
    buf_left_d    = buf_left_q;
    buf_right_d   = buf_right_q;
    fall          = 1'b0;
    load          = 1'b0;
    xfer          = s.s_valid && s_ready_q;

    if (state_q == RUN && lock_s_q) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d  = '0;
        bclk_d = ~bclk_q;
        fall   = bclk_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end

      if (fall) begin
        b_d    = (b_q == B_LAST) ? '0 : b_q + B_W'(1);
        lrck_d = (b_d >= LR_LO) && (b_d <= LR_HI);
        load   = (b_d == '0);
        if (load) begin
          dout_d        = frame_new[FRAME_W-1];
          shreg_d       = frame_new << 1;
          frame_start_d = 1'b1;
          underrun_d    = underrun_q | ~buf_valid_q;
          buf_valid_d   = 1'b0;
        end else begin
          dout_d  = shreg_q[FRAME_W-1];
          shreg_d = shreg_q << 1;
        end
      end

      // A pair arriving on an empty-buffer load cycle is kept for the next frame.
      if (xfer) begin
        buf_valid_d = 1'b1;
        buf_left_d  = s.s_left;
        buf_right_d = s.s_right;
      end
    end else begin
      state_d     = (state_q == IDLE && lock_s_q) ? RUN : IDLE;
      cnt_d       = '0;
      b_d         = B_LAST;
      bclk_d      = 1'b0;
      lrck_d      = 1'b0;
      dout_d      = 1'b0;
      shreg_d     = '0;
      buf_valid_d = 1'b0;
    end

    s_ready_d = (state_d == RUN) && !buf_valid_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      lock_meta_q   <= 1'b0;
      lock_s_q      <= 1'b0;
      cnt_q         <= '0;
      b_q           <= '0;
      bclk_q        <= 1'b0;
      lrck_q        <= 1'b0;
      dout_q        <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
      s_ready_q     <= 1'b0;
      shreg_q       <= '0;
      buf_valid_q   <= 1'b0;
      buf_left_q    <= '0;
      buf_right_q   <= '0;
    end else begin
      state_q       <= state_d;
      lock_meta_q   <= pll_locked;
      lock_s_q      <= lock_meta_q;
      cnt_q         <= cnt_d;
      b_q           <= b_d;
      bclk_q        <= bclk_d;
      lrck_q        <= lrck_d;
      dout_q        <= dout_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
      s_ready_q     <= s_ready_d;
      shreg_q       <= shreg_d;
      buf_valid_q   <= buf_valid_d;
      buf_left_q    <= buf_left_d;
      buf_right_q   <= buf_right_d;
    end
  end

  assign s.s_ready   = s_ready_q;
  assign i2s_bclk    = bclk_q;
  assign i2s_lrck    = lrck_q;
  assign i2s_dout    = dout_q;
  assign frame_start = frame_start_q;
  assign underrun    = underrun_q;
endmodule
